// File: rtl/video_frame_monitor.sv
// video_frame_monitor
// Watches a pixel stream framed by de / end_line / end_frame. It counts pixels
// per line and active lines per frame, and accumulates a rotate-and-add
// checksum over every valid pixel. Per-frame results are published with a
// one-cycle frame_valid pulse. Geometry mismatches against the expected
// H_ACTIVE / V_ACTIVE raise sticky error flags. After NUM_FRAMES captured
// frames the monitor parks in DONE and holds its results.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | disarmed; working counters held at zero
// WAIT_SOF  | armed, waiting for the first end_line&end_frame to align
// CAPTURE   | counting pixels/lines and accumulating the checksum
// DONE      | NUM_FRAMES frames captured; all outputs frozen
module video_frame_monitor #(
  parameter int CH_WIDTH   = 8,
  parameter int CHANNELS   = 3,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int NUM_FRAMES = 1,
  parameter int CNT_W      = 12
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         clear,
  input  logic                         de,
  input  logic [CHANNELS*CH_WIDTH-1:0] pixel,
  input  logic                         end_line,
  input  logic                         end_frame,
  output logic [15:0]                  frame_cnt,
  output logic [CNT_W-1:0]             line_pix,
  output logic [CNT_W-1:0]             frame_lines,
  output logic [31:0]                  checksum,
  output logic                         frame_valid,
  output logic                         h_err,
  output logic                         v_err,
  output logic                         done,
  output logic [1:0]                   state
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_CAPTURE  = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] H_EXPECT   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_EXPECT   = CNT_W'(V_ACTIVE);
  localparam logic [15:0]      FRAMES_TGT = 16'(NUM_FRAMES);
  localparam logic [15:0]      FCNT_MAX   = 16'hFFFF;

  state_e state_q, state_d;

  // Working registers (discarded whenever capture is interrupted)
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
  logic [31:0]      acc_q, acc_d;

  // Published results
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] line_pix_q, line_pix_d;
  logic [CNT_W-1:0] frame_lines_q, frame_lines_d;
  logic [31:0]      checksum_q, checksum_d;
  logic             frame_valid_q, frame_valid_d;
  logic             h_err_q, h_err_d;
  logic             v_err_q, v_err_d;

  // Values as they stand once the current cycle's pixel has been folded in
  logic [31:0]      pix_sum;
  logic [CNT_W-1:0] pix_fin;
  logic [CNT_W-1:0] line_fin;
  logic [31:0]      acc_fin;
  logic [15:0]      frame_cnt_inc;
  logic             line_nz;
  logic             line_bad;
  logic             frame_bad;
  logic             frame_evt;
  logic             capturing;
  logic             frame_last;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [31:0] channel_sum(input logic [CHANNELS*CH_WIDTH-1:0] p);
    logic [31:0] s;
    s = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      s = s + 32'(p[c*CH_WIDTH +: CH_WIDTH]);
    end
    return s;
  endfunction

  // Per-cycle arithmetic shared by the FSM and the datapath
  always_comb begin
    frame_evt     = end_line & end_frame;
    capturing     = (state_q == ST_CAPTURE) && enable && !clear;
    pix_sum       = channel_sum(pixel);
    pix_fin       = de ? sat_inc(pix_cnt_q) : pix_cnt_q;
    acc_fin       = de ? ({acc_q[30:0], acc_q[31]} + pix_sum) : acc_q;
    line_nz       = (pix_fin != '0);
    line_fin      = line_nz ? sat_inc(line_cnt_q) : line_cnt_q;
    // An all-ones count means it saturated and the true length is unknown
    line_bad      = (pix_fin != H_EXPECT) || (pix_fin == CNT_MAX);
    frame_bad     = (line_fin != V_EXPECT) || (line_fin == CNT_MAX);
    frame_cnt_inc = (frame_cnt_q == FCNT_MAX) ? frame_cnt_q : frame_cnt_q + 16'd1;
    frame_last    = capturing && frame_evt && (frame_cnt_inc >= FRAMES_TGT);
  end

  // FSM next-state: clear beats enable, enable low beats everything else
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = enable ? ST_WAIT_SOF : ST_IDLE;
    end else if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:     state_d = ST_WAIT_SOF;
        ST_WAIT_SOF: if (frame_evt) state_d = ST_CAPTURE;
        ST_CAPTURE:  if (frame_last) state_d = ST_DONE;
        ST_DONE:     state_d = ST_DONE;
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath next-state: counting, line/frame closing and result publishing
  always_comb begin
    pix_cnt_d     = pix_cnt_q;
    line_cnt_d    = line_cnt_q;
    acc_d         = acc_q;
    frame_cnt_d   = frame_cnt_q;
    line_pix_d    = line_pix_q;
    frame_lines_d = frame_lines_q;
    checksum_d    = checksum_q;
    frame_valid_d = 1'b0;
    h_err_d       = h_err_q;
    v_err_d       = v_err_q;

    if (clear) begin
      pix_cnt_d     = '0;
      line_cnt_d    = '0;
      acc_d         = '0;
      frame_cnt_d   = '0;
      line_pix_d    = '0;
      frame_lines_d = '0;
      checksum_d    = '0;
      h_err_d       = 1'b0;
      v_err_d       = 1'b0;
    end else if (!capturing) begin
      // Outside CAPTURE any partial frame is dropped; published values stay
      pix_cnt_d  = '0;
      line_cnt_d = '0;
      acc_d      = '0;
    end else begin
      pix_cnt_d = pix_fin;
      acc_d     = acc_fin;

      if (end_line) begin
        pix_cnt_d = '0;
        // Blanking lines leave line_pix, line_cnt and h_err untouched
        if (line_nz) begin
          line_pix_d = pix_fin;
          line_cnt_d = line_fin;
          if (line_bad) h_err_d = 1'b1;
        end
      end

      if (frame_evt) begin
        frame_lines_d = line_fin;
        checksum_d    = acc_fin;
        frame_cnt_d   = frame_cnt_inc;
        frame_valid_d = 1'b1;
        if (frame_bad) v_err_d = 1'b1;
        line_cnt_d    = '0;
        acc_d         = '0;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_cnt_q     <= '0;
      line_cnt_q    <= '0;
      acc_q         <= '0;
      frame_cnt_q   <= '0;
      line_pix_q    <= '0;
      frame_lines_q <= '0;
      checksum_q    <= '0;
      frame_valid_q <= 1'b0;
      h_err_q       <= 1'b0;
      v_err_q       <= 1'b0;
    end else begin
      pix_cnt_q     <= pix_cnt_d;
      line_cnt_q    <= line_cnt_d;
      acc_q         <= acc_d;
      frame_cnt_q   <= frame_cnt_d;
      line_pix_q    <= line_pix_d;
      frame_lines_q <= frame_lines_d;
      checksum_q    <= checksum_d;
      frame_valid_q <= frame_valid_d;
      h_err_q       <= h_err_d;
      v_err_q       <= v_err_d;
    end
  end

  assign frame_cnt   = frame_cnt_q;
  assign line_pix    = line_pix_q;
  assign frame_lines = frame_lines_q;
  assign checksum    = checksum_q;
  assign frame_valid = frame_valid_q;
  assign h_err       = h_err_q;
  assign v_err       = v_err_q;
  assign done        = (state_q == ST_DONE);
  assign state       = state_q;

endmodule

// File: tb/tb_video_frame_monitor.sv
// Testbench for video_frame_monitor: randomized line/frame stimulus, a
// frame-level reference model, and a scoreboard monitor on frame_valid.
module tb_video_frame_monitor;

  localparam int CH_WIDTH   = 8;
  localparam int CHANNELS   = 3;
  localparam int H_ACTIVE   = 4;
  localparam int V_ACTIVE   = 3;
  localparam int NUM_FRAMES = 2;
  localparam int CNT_W      = 12;
  localparam int PW         = CH_WIDTH * CHANNELS;

  logic clk = 1'b0;
  logic reset, enable, clear, de, end_line, end_frame;
  logic [PW-1:0]    pixel;
  logic [15:0]      frame_cnt;
  logic [CNT_W-1:0] line_pix, frame_lines;
  logic [31:0]      checksum;
  logic             frame_valid, h_err, v_err, done;
  logic [1:0]       state;

  video_frame_monitor #(
    .CH_WIDTH(CH_WIDTH), .CHANNELS(CHANNELS), .H_ACTIVE(H_ACTIVE),
    .V_ACTIVE(V_ACTIVE), .NUM_FRAMES(NUM_FRAMES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .de(de),
    .pixel(pixel), .end_line(end_line), .end_frame(end_frame),
    .frame_cnt(frame_cnt), .line_pix(line_pix), .frame_lines(frame_lines),
    .checksum(checksum), .frame_valid(frame_valid), .h_err(h_err),
    .v_err(v_err), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CNT_W-1:0] lines;
    logic [31:0]      csum;
    logic [15:0]      fcnt;
    logic [CNT_W-1:0] lpix;
    logic             herr;
    logic             verr;
  } exp_t;

  exp_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: 0 idle, 1 waiting for sync, 2 capturing, 3 done
  int          m_mode;
  int          m_lines;
  logic [31:0] m_acc;
  int          m_frame_cnt;
  int          m_line_pix;
  int          m_frame_lines;
  logic [31:0] m_checksum;
  bit          m_h_err, m_v_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] px_sum(input logic [PW-1:0] p);
    return 32'(p[7:0]) + 32'(p[15:8]) + 32'(p[23:16]);
  endfunction

  task automatic m_clear();
    m_lines = 0; m_acc = 0; m_frame_cnt = 0; m_line_pix = 0;
    m_frame_lines = 0; m_checksum = 0; m_h_err = 0; m_v_err = 0;
    m_mode = enable ? 1 : 0;
  endtask

  // One clock of stimulus, applied at the falling edge
  task automatic cyc(input logic d, input logic [PW-1:0] p, input logic el,
                     input logic ef, input logic cl);
    @(negedge clk);
    de = d; pixel = p; end_line = el; end_frame = ef; clear = cl;
  endtask

  // Idle cycles with junk pixel data and stray end_frame (no end_line)
  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cyc(1'b0, PW'($urandom), 1'b0, ($urandom_range(0, 3) == 0), 1'b0);
  endtask

  task automatic send_line(input int npix, input bit overlap, input bit last,
                           input bit fixed, input bit clr);
    int cnt;
    bit cap, is_end;
    logic [PW-1:0] p;
    exp_t e;
    cnt = 0;
    cap = (m_mode == 2);
    for (int i = 0; i < npix; i++) begin
      p = fixed ? PW'(24'h010203) : PW'($urandom);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      is_end = overlap && (i == npix - 1);
      cyc(1'b1, p, is_end, is_end && last, is_end && clr);
      if (cap && !(is_end && clr)) begin
        cnt++;
        m_acc = ((m_acc << 1) | (m_acc >> 31)) + px_sum(p);
      end
    end
    if (!(overlap && npix > 0)) begin
      idle($urandom_range(0, 2));
      cyc(1'b0, PW'($urandom), 1'b1, last, clr);
    end
    if (clr) begin
      m_clear();
    end else if (cap) begin
      if (cnt > 0) begin
        m_line_pix = cnt;
        m_lines++;
        if (cnt != H_ACTIVE) m_h_err = 1;
      end
      if (last) begin
        m_frame_lines = m_lines;
        m_checksum    = m_acc;
        if (m_frame_cnt < 65535) m_frame_cnt++;
        if (m_lines != V_ACTIVE) m_v_err = 1;
        e.lines = CNT_W'(m_frame_lines); e.csum = m_checksum;
        e.fcnt  = 16'(m_frame_cnt);      e.lpix = CNT_W'(m_line_pix);
        e.herr  = m_h_err;               e.verr = m_v_err;
        exp_q.push_back(e);
        m_lines = 0; m_acc = 0;
        if (m_frame_cnt >= NUM_FRAMES) m_mode = 3;
      end
    end else if (m_mode == 1 && last) begin
      m_mode = 2;
    end
  endtask

  task automatic send_frame(input int nlines, input int npix, input bit fixed);
    for (int l = 0; l < nlines; l++)
      send_line(npix, $urandom_range(0, 1), l == nlines - 1, fixed, 1'b0);
  endtask

  task automatic sync();
    send_line($urandom_range(0, 3), 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_clear();
    cyc(1'b0, PW'($urandom), 1'b0, 1'b0, 1'b1);
    m_clear();
    idle(1);
  endtask

  task automatic en_on();
    enable = 1'b1;
    idle(1);
    if (m_mode == 0) m_mode = 1;
  endtask

  task automatic en_off();
    enable = 1'b0;
    idle(1);
    m_mode = 0; m_lines = 0; m_acc = 0;
  endtask

  task automatic check_all(input string tag, input bit settle);
    if (settle) idle(2);
    chk({tag, ".frame_cnt"},   32'(frame_cnt),   32'(m_frame_cnt));
    chk({tag, ".line_pix"},    32'(line_pix),    32'(m_line_pix));
    chk({tag, ".frame_lines"}, 32'(frame_lines), 32'(m_frame_lines));
    chk({tag, ".checksum"},    checksum,         m_checksum);
    chk({tag, ".h_err"},       32'(h_err),       32'(m_h_err));
    chk({tag, ".v_err"},       32'(v_err),       32'(m_v_err));
    chk({tag, ".done"},        32'(done),        32'(m_mode == 3));
    chk({tag, ".state"},       32'(state),       32'(m_mode));
  endtask

  // Scoreboard monitor: every frame_valid pulse must match the next expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && frame_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb.unexpected_frame_valid: got pulse, required none");
        end else begin
          e = exp_q.pop_front();
          chk("sb.frame_lines", 32'(frame_lines), 32'(e.lines));
          chk("sb.checksum",    checksum,         e.csum);
          chk("sb.frame_cnt",   32'(frame_cnt),   32'(e.fcnt));
          chk("sb.line_pix",    32'(line_pix),    32'(e.lpix));
          chk("sb.h_err",       32'(h_err),       32'(e.herr));
          chk("sb.v_err",       32'(v_err),       32'(e.verr));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; clear = 1'b0; de = 1'b0;
    pixel = '0; end_line = 1'b0; end_frame = 1'b0;
    m_clear();
    repeat (3) @(negedge clk);
    check_all("reset", 1'b0);
    chk("reset.frame_valid", 32'(frame_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    check_all("idle", 1'b1);

    // Two fixed 3x4 frames of 0x010203, then a frame while DONE
    en_on();
    chk("armed.state", 32'(state), 32'd1);
    sync();
    send_frame(3, 4, 1'b1);
    check_all("frame1", 1'b1);
    chk("frame1.checksum_const", checksum, 32'd24570);
    send_frame(3, 4, 1'b1);
    check_all("frame2_done", 1'b1);
    send_frame(3, 4, 1'b0);
    check_all("done_hold", 1'b1);

    // Long line with a pixel on the end_line cycle, then good lines
    do_clear();
    check_all("clear", 1'b0);
    sync();
    send_line(5, 1'b1, 1'b0, 1'b0, 1'b0);
    send_line(4, 1'b0, 1'b0, 1'b0, 1'b0);
    send_line(4, 1'b1, 1'b1, 1'b0, 1'b0);
    check_all("h_err_set", 1'b1);
    send_frame(3, 4, 1'b0);
    check_all("h_err_sticky", 1'b1);

    // Two active lines surrounded by blanking lines
    do_clear();
    sync();
    send_line(3, 1'b0, 1'b0, 1'b0, 1'b0);
    send_line(0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_line(4, 1'b1, 1'b0, 1'b0, 1'b0);
    send_line(0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_all("v_err_blank", 1'b1);

    // Randomized frames
    for (int r = 0; r < 6; r++) begin
      do_clear();
      sync();
      for (int f = 0; f < 2; f++) begin
        int nl;
        nl = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : 3;
        for (int l = 0; l < nl; l++)
          send_line(($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : 4,
                    $urandom_range(0, 1), l == nl - 1, 1'b0, 1'b0);
      end
      check_all("random", 1'b1);
    end

    // clear coinciding with end_line&end_frame
    do_clear();
    sync();
    send_line(4, 1'b0, 1'b0, 1'b0, 1'b0);
    send_line(4, 1'b1, 1'b0, 1'b0, 1'b0);
    send_line(4, 1'b1, 1'b1, 1'b0, 1'b1);
    check_all("clear_vs_frame", 1'b1);

    // enable dropped mid-frame: partial frame discarded, results kept
    sync();
    send_frame(3, 4, 1'b0);
    send_line(4, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, PW'($urandom), 1'b0, 1'b0, 1'b0);
    en_off();
    check_all("enable_drop", 1'b1);
    en_on();
    sync();
    send_frame(3, 4, 1'b0);
    check_all("reenable", 1'b1);

    // Asynchronous reset in the middle of a line
    do_clear();
    sync();
    send_frame(3, 4, 1'b0);
    send_line(4, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, PW'($urandom), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, PW'($urandom), 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    m_clear();
    m_mode = 0;
    check_all("async_reset", 1'b0);
    chk("async_reset.frame_valid", 32'(frame_valid), 32'd0);
    @(negedge clk);
    de = 1'b0; end_line = 1'b0; end_frame = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    idle(1);
    m_mode = 1;
    check_all("after_reset", 1'b1);
    idle(4);

    chk("sb.empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/video_frame_monitor.md
VIDEO_FRAME_MONITOR -- requirements
Module: video_frame_monitor

Interface
REQ-001 Parameter CH_WIDTH, default 8: bits per colour channel.
REQ-002 Parameter CHANNELS, default 3: channels per pixel; channel 0 in the LSBs.
REQ-003 Parameter H_ACTIVE, default 640: expected active pixels per line.
REQ-004 Parameter V_ACTIVE, default 480: expected active lines per frame.
REQ-005 Parameter NUM_FRAMES, default 1: frames captured before DONE; legal range is 1 to 65535.
REQ-006 Parameter CNT_W, default 12: width of the pixel and line counters.
REQ-007 clk  in  1: single clock (pixel clock); all logic is on its rising edge.
REQ-008 reset  in  1: asynchronous, active-high reset.
REQ-009 enable  in  1: arms capture; when low, the FSM goes to IDLE.
REQ-010 clear  in  1: synchronous restart of counters, flags and FSM.
REQ-011 de  in  1: data enable; the pixel is valid when high.
REQ-012 pixel  in  CHANNELS*CH_WIDTH: pixel data.
REQ-013 end_line  in  1: one-cycle strobe on the last cycle of each total line.
REQ-014 end_frame  in  1: last line of the frame; valid only together with end_line.
REQ-015 frame_cnt  out  16: number of frames captured.
REQ-016 line_pix  out  CNT_W: pixel count of the most recent non-empty line.
REQ-017 frame_lines  out  CNT_W: active-line count of the last completed frame.
REQ-018 checksum  out  32: checksum of the last completed frame.
REQ-019 frame_valid  out  1: one-cycle pulse when frame results update.
REQ-020 h_err, v_err  out  1 each: sticky timing-error flags.
REQ-021 done  out  1: high while the FSM is in DONE.
REQ-022 state  out  2: FSM state encoding; IDLE=0, WAIT_SOF=1, CAPTURE=2, DONE=3.

Function
REQ-023 FSM transitions: IDLE->WAIT_SOF when enable=1; WAIT_SOF->CAPTURE on a cycle with end_line&end_frame; CAPTURE->DONE at the frame end where frame_cnt reaches NUM_FRAMES; any state->IDLE when enable=0.
REQ-024 In WAIT_SOF, de and pixel SHALL be ignored; no counter or checksum changes.
REQ-025 In CAPTURE, each cycle with de=1 SHALL increment pix_cnt and update acc.
- Checksum update: acc <= rotl1(acc) + zero-extended sum of all CHANNELS channel values, modulo 2^32.
REQ-026 When de=1 and end_line=1 occur on the same cycle, that pixel SHALL count toward the ending line.
REQ-027 At end_line in CAPTURE with a non-zero final pix_cnt:
- line_pix <= the final count;
- line_cnt increments;
- h_err is set if the count is not H_ACTIVE;
- pix_cnt returns to 0.
REQ-028 Lines with zero pixels (blanking) SHALL NOT change line_pix, line_cnt or h_err.
REQ-029 At end_line&end_frame in CAPTURE, one cycle later:
- frame_lines <= final line_cnt;
- checksum <= final acc;
- frame_cnt increments;
- frame_valid pulses for one cycle;
- v_err is set if the line count is not V_ACTIVE;
- line_cnt and acc return to 0.
REQ-030 end_frame without end_line SHALL be ignored in every state.
REQ-031 pix_cnt and line_cnt SHALL saturate at all-ones, never wrap, and a saturated count SHALL flag the corresponding error.
REQ-032 frame_cnt SHALL saturate at 65535.
REQ-033 In DONE, all outputs SHALL hold until clear or enable=0.
REQ-034 When clear=1, the block SHALL zero all counters, acc, outputs and flags, and move to WAIT_SOF if enable=1, else IDLE; clear has priority over every other event in the same cycle.
REQ-035 enable falling mid-frame SHALL discard the partial frame; published outputs are kept.

Reset
REQ-036 While reset is asserted, asynchronously:
- state=IDLE;
- all counters, acc, frame_cnt, line_pix, frame_lines and checksum are 0;
- frame_valid, h_err, v_err and done are 0.
REQ-037 Reset deassertion SHALL NOT generate a frame_valid pulse; a reset mid-frame discards that frame.

Verification (CH_WIDTH=8, CHANNELS=3, H_ACTIVE=4, V_ACTIVE=3, NUM_FRAMES=2)
REQ-038 Enable, one sync frame, then 3 lines of 4 pixels, each pixel 0x010203 -> frame_valid pulses once; frame_lines=3; line_pix=4; frame_cnt=1; h_err=v_err=0; checksum equals the REQ-025 model value.
REQ-039 Second identical frame -> frame_cnt=2, done=1, state=3; a further frame leaves all outputs unchanged.
REQ-040 A line of 5 pixels with de=1 on the end_line cycle -> line_pix=5, h_err=1 and stays set through later good lines.
REQ-041 Frame of 2 active lines plus blank lines -> frame_lines=2, v_err=1; blank lines do not alter line_pix.
REQ-042 clear and end_line&end_frame on the same cycle -> no frame_valid pulse, all outputs 0, state=WAIT_SOF.
REQ-043 reset pulsed mid-line in CAPTURE -> outputs 0 immediately, state=IDLE, no frame_valid pulse after release.
